temp_digit_split: RTL and testbench

- Upstream feeder of the 4-digit 7-segment display scanner.
- Converts a binary temperature sample into the display's unit digit (uni) and decade-offset code (dec, tens minus 2).
- Clamps the sample to the displayable range and flags out-of-range samples.
- Holds its digit outputs stable between conversions, so the scanner can read them every cycle.

---
 rtl/temp_digit_split_pkg.sv | 18 +
 rtl/temp_digit_split.sv | 125 ++++++++++++
 tb/tb_temp_digit_split.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/temp_digit_split_pkg.sv
// Shared display constants: converter state encoding, displayable range defaults
// and the decade step/base used by both this converter and the scanner decode.
package temp_digit_split_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StSub   = 2'd2,
    StLoad  = 2'd3
  } split_state_e;

  localparam int unsigned T_MIN_DEF = 20;
  localparam int unsigned T_MAX_DEF = 59;
  localparam int unsigned DEC_STEP  = 10;
  // dec = tens - DEC_BASE; the scanner adds it back when decoding.
  localparam int unsigned DEC_BASE  = 2;

endpackage

// File: rtl/temp_digit_split.sv
// Clamps a binary temperature sample and splits it into unit digit and tens-minus-2 code
// by repeated subtraction. Optional macro TEMP_SPLIT_PEND_EN keeps one pending sample.
module temp_digit_split
  import temp_digit_split_pkg::*;
#(
  parameter int unsigned TEMP_W = 6,
  parameter int unsigned T_MIN  = T_MIN_DEF,
  parameter int unsigned T_MAX  = T_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] temp,
  input  logic              temp_vld,
  output logic [4:0]        uni,
  output logic [1:0]        dec,
  output logic              range_err,
  output logic              busy,
  output logic              done
);

  localparam logic [TEMP_W-1:0] TMinW  = TEMP_W'(T_MIN);
  localparam logic [TEMP_W-1:0] TMaxW  = TEMP_W'(T_MAX);
  localparam logic [TEMP_W-1:0] TSpanW = TEMP_W'(T_MAX - T_MIN);
  localparam logic [TEMP_W-1:0] StepW  = TEMP_W'(DEC_STEP);

  if (T_MAX < T_MIN || T_MAX - T_MIN > 39) begin : g_range_check
    $error("temp_digit_split: T_MAX - T_MIN must be in 0..39");
  end

  split_state_e      state;
  logic [TEMP_W-1:0] work;
  logic [1:0]        tens;
  logic              err;

`ifdef TEMP_SPLIT_PEND_EN
  logic [TEMP_W-1:0] pend;
  logic              pend_vld;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      work      <= '0;
      tens      <= '0;
      err       <= 1'b0;
      uni       <= '0;
      dec       <= '0;
      range_err <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef TEMP_SPLIT_PEND_EN
      pend      <= '0;
      pend_vld  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef TEMP_SPLIT_PEND_EN
      if (temp_vld && state != StIdle) begin
        pend     <= temp;
        pend_vld <= 1'b1;
      end
`endif
      unique case (state)
        StIdle: begin
          if (temp_vld) begin
            work  <= temp;
            busy  <= 1'b1;
            state <= StCheck;
          end
        end
        StCheck: begin
          if (work < TMinW) begin
            work <= '0;
            err  <= 1'b1;
          end else if (work > TMaxW) begin
            work <= TSpanW;
            err  <= 1'b1;
          end else begin
            work <= work - TMinW;
            err  <= 1'b0;
          end
          tens  <= '0;
          state <= StSub;
        end
        StSub: begin
          if (work >= StepW) begin
            work <= work - StepW;
            tens <= tens + 2'd1;
          end else begin
            state <= StLoad;
          end
        end
        StLoad: begin
          uni       <= {1'b0, work[3:0]};
          dec       <= tens;
          range_err <= err;
          done      <= 1'b1;
`ifdef TEMP_SPLIT_PEND_EN
          // A strobe landing in this very cycle is newer than anything pending.
          if (temp_vld) begin
            work     <= temp;
            pend_vld <= 1'b0;
            state    <= StCheck;
          end else if (pend_vld) begin
            work     <= pend;
            pend_vld <= 1'b0;
            state    <= StCheck;
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
`else
          busy  <= 1'b0;
          state <= StIdle;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_digit_split.sv
// Randomized self-checking bench for temp_digit_split against a clamp/divide reference model.
module tb_temp_digit_split;

  localparam int TMin = 20;
  localparam int TMax = 59;

  logic       clk;
  logic       rst_n;
  logic [5:0] temp;
  logic       temp_vld;
  logic [4:0] uni;
  logic [1:0] dec;
  logic       range_err;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  int         inject_at  = -1;
  logic [5:0] inject_val = '0;

  temp_digit_split dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .temp      (temp),
    .temp_vld  (temp_vld),
    .uni       (uni),
    .dec       (dec),
    .range_err (range_err),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: clamp into [TMin, TMax], offset, then plain decimal split.
  function automatic int ref_val(input int t);
    if (t < TMin) return 0;
    if (t > TMax) return TMax - TMin;
    return t - TMin;
  endfunction

  function automatic bit ref_err(input int t);
    return (t < TMin) || (t > TMax);
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, ".uni"}, int'(uni), 0);
    check_eq({tag, ".dec"}, int'(dec), 0);
    check_eq({tag, ".err"}, int'(range_err), 0);
    check_eq({tag, ".busy"}, int'(busy), 0);
    check_eq({tag, ".done"}, int'(done), 0);
  endtask

  // Counts `edges` edges; done must be low with busy high until the last, then values checked.
  task automatic expect_done(input string tag, input int edges, input int t, input bit ebusy);
    int v;
    v = ref_val(t);
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk);
      @(negedge clk);
      temp_vld = (k == inject_at);
      if (k == inject_at) temp = inject_val;
      if (k < edges) begin
        if (done !== 1'b0) check_eq({tag, ".early_done"}, int'(done), 0);
        check_eq({tag, ".busy_mid"}, int'(busy), 1);
      end
    end
    inject_at = -1;
    check_eq({tag, ".done"}, int'(done), 1);
    check_eq({tag, ".uni"}, int'(uni), v % 10);
    check_eq({tag, ".dec"}, int'(dec), v / 10);
    check_eq({tag, ".err"}, int'(range_err), int'(ref_err(t)));
    check_eq({tag, ".busy_end"}, int'(busy), int'(ebusy));
  endtask

  task automatic run_conv(input string tag, input int t);
    @(negedge clk);
    temp     = 6'(t);
    temp_vld = 1'b1;
    expect_done(tag, 4 + ref_val(t) / 10, t, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, int'(done), 0);
    check_eq({tag, ".idle"}, int'(busy), 0);
  endtask

  initial begin
    int t;
    int lat;
    int bounds[10] = '{0, 5, 19, 20, 29, 30, 37, 59, 60, 63};

    rst_n    = 1'b0;
    temp     = '0;
    temp_vld = 1'b0;

    // Reset held while strobes toggle: everything must stay at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      temp_vld = ~temp_vld;
      temp     = 6'(37 + i);
      check_zero("reset");
    end
    @(negedge clk);
    temp_vld = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 10; i++) run_conv("bound", bounds[i]);

    // Second strobe two cycles after the first.
    @(negedge clk);
    temp       = 6'd37;
    temp_vld   = 1'b1;
    inject_at  = 2;
    inject_val = 6'd45;
`ifdef TEMP_SPLIT_PEND_EN
    expect_done("pend1", 5, 37, 1'b1);
    expect_done("pend2", 5, 45, 1'b0);
`else
    expect_done("drop", 5, 37, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0) check_eq("drop.extra_done", int'(done), 0);
    end
    check_eq("drop.hold_uni", int'(uni), 7);
    check_eq("drop.hold_dec", int'(dec), 1);
`endif

    // Reset during SUB aborts the conversion without a done pulse.
    @(negedge clk);
    temp     = 6'd58;
    temp_vld = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      temp_vld = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_zero("abort_hold");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_zero("abort_after");
    end
    run_conv("post_abort", 24);

    // Random samples with idle gaps; extra strobes while busy are dropped by default.
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(63, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      lat = 4 + ref_val(t) / 10;
`ifndef TEMP_SPLIT_PEND_EN
      if ($urandom_range(1, 0) == 1) begin
        inject_at  = int'($urandom_range(lat - 1, 1));
        inject_val = 6'($urandom_range(63, 0));
      end
`endif
      run_conv("rand", t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
